// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded descriptors into machine words
// and streams them into instruction memory over a held-request/ack port.
package instr_encoder_pkg;
    typedef enum logic [5:0] {
        INSTR_ILLEGAL = 6'd0,
        INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
        INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
        INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
        INSTR_SB, INSTR_SH, INSTR_SW,
        INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI,
        INSTR_ANDI, INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
        INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
        INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND
    } rv32i_instr_e;
endpackage

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_instr,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_written,
    output logic              done
);
    typedef enum logic [1:0] {S_ACCEPT, S_WRITE, S_DONE} state_e;
    typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_BAD} fmt_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]    words_q, words_d;
    logic               last_q, last_d;
    logic               full_q, full_d;
    logic               err_valid_q, err_valid_d;
    logic [1:0]         err_code_q, err_code_d;

    fmt_e               fmt;
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic               imm_ok;
    logic [31:0]        enc;
    logic signed [31:0] imm_s;
    logic               legal;

    assign imm_s = in_imm;

    always_comb begin
        fmt = F_BAD;
        opc = 7'h00;
        f3  = 3'd0;
        f7  = 7'h00;
        case (in_instr)
            INSTR_LUI:   begin fmt = F_U;  opc = 7'h37; end
            INSTR_AUIPC: begin fmt = F_U;  opc = 7'h17; end
            INSTR_JAL:   begin fmt = F_J;  opc = 7'h6f; end
            INSTR_JALR:  begin fmt = F_I;  opc = 7'h67; end
            INSTR_BEQ:   begin fmt = F_B;  opc = 7'h63; f3 = 3'd0; end
            INSTR_BNE:   begin fmt = F_B;  opc = 7'h63; f3 = 3'd1; end
            INSTR_BLT:   begin fmt = F_B;  opc = 7'h63; f3 = 3'd4; end
            INSTR_BGE:   begin fmt = F_B;  opc = 7'h63; f3 = 3'd5; end
            INSTR_BLTU:  begin fmt = F_B;  opc = 7'h63; f3 = 3'd6; end
            INSTR_BGEU:  begin fmt = F_B;  opc = 7'h63; f3 = 3'd7; end
            INSTR_LB:    begin fmt = F_I;  opc = 7'h03; f3 = 3'd0; end
            INSTR_LH:    begin fmt = F_I;  opc = 7'h03; f3 = 3'd1; end
            INSTR_LW:    begin fmt = F_I;  opc = 7'h03; f3 = 3'd2; end
            INSTR_LBU:   begin fmt = F_I;  opc = 7'h03; f3 = 3'd4; end
            INSTR_LHU:   begin fmt = F_I;  opc = 7'h03; f3 = 3'd5; end
            INSTR_SB:    begin fmt = F_S;  opc = 7'h23; f3 = 3'd0; end
            INSTR_SH:    begin fmt = F_S;  opc = 7'h23; f3 = 3'd1; end
            INSTR_SW:    begin fmt = F_S;  opc = 7'h23; f3 = 3'd2; end
            INSTR_ADDI:  begin fmt = F_I;  opc = 7'h13; f3 = 3'd0; end
            INSTR_SLTI:  begin fmt = F_I;  opc = 7'h13; f3 = 3'd2; end
            INSTR_SLTIU: begin fmt = F_I;  opc = 7'h13; f3 = 3'd3; end
            INSTR_XORI:  begin fmt = F_I;  opc = 7'h13; f3 = 3'd4; end
            INSTR_ORI:   begin fmt = F_I;  opc = 7'h13; f3 = 3'd6; end
            INSTR_ANDI:  begin fmt = F_I;  opc = 7'h13; f3 = 3'd7; end
            INSTR_SLLI:  begin fmt = F_SH; opc = 7'h13; f3 = 3'd1; end
            INSTR_SRLI:  begin fmt = F_SH; opc = 7'h13; f3 = 3'd5; end
            INSTR_SRAI:  begin fmt = F_SH; opc = 7'h13; f3 = 3'd5; f7 = 7'h20; end
            INSTR_ADD:   begin fmt = F_R;  opc = 7'h33; f3 = 3'd0; end
            INSTR_SUB:   begin fmt = F_R;  opc = 7'h33; f3 = 3'd0; f7 = 7'h20; end
            INSTR_SLL:   begin fmt = F_R;  opc = 7'h33; f3 = 3'd1; end
            INSTR_SLT:   begin fmt = F_R;  opc = 7'h33; f3 = 3'd2; end
            INSTR_SLTU:  begin fmt = F_R;  opc = 7'h33; f3 = 3'd3; end
            INSTR_XOR:   begin fmt = F_R;  opc = 7'h33; f3 = 3'd4; end
            INSTR_SRL:   begin fmt = F_R;  opc = 7'h33; f3 = 3'd5; end
            INSTR_SRA:   begin fmt = F_R;  opc = 7'h33; f3 = 3'd5; f7 = 7'h20; end
            INSTR_OR:    begin fmt = F_R;  opc = 7'h33; f3 = 3'd6; end
            INSTR_AND:   begin fmt = F_R;  opc = 7'h33; f3 = 3'd7; end
            default:     fmt = F_BAD;
        endcase
    end

    // Field packing and immediate range check per instruction format
    always_comb begin
        imm_ok = 1'b0;
        enc    = 32'h0;
        case (fmt)
            F_R: begin
                imm_ok = 1'b1;
                enc    = {f7, in_rs2, in_rs1, f3, in_rd, opc};
            end
            F_I: begin
                imm_ok = imm_s >= -32'sd2048 && imm_s <= 32'sd2047;
                enc    = {in_imm[11:0], in_rs1, f3, in_rd, opc};
            end
            F_SH: begin
                imm_ok = in_imm < 32'd32;
                enc    = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
            end
            F_S: begin
                imm_ok = imm_s >= -32'sd2048 && imm_s <= 32'sd2047;
                enc    = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
            end
            F_B: begin
                imm_ok = imm_s >= -32'sd4096 && imm_s <= 32'sd4094 && !in_imm[0];
                enc    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                          in_imm[4:1], in_imm[11], opc};
            end
            F_U: begin
                imm_ok = in_imm[11:0] == 12'h000;
                enc    = {in_imm[31:12], in_rd, opc};
            end
            F_J: begin
                imm_ok = imm_s >= -32'sd1048576 && imm_s <= 32'sd1048574 && !in_imm[0];
                enc    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                          in_rd, opc};
            end
            default: begin
                imm_ok = 1'b0;
                enc    = 32'h0;
            end
        endcase
    end

    assign legal = fmt != F_BAD && imm_ok && !full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ACCEPT;
            mem_addr_q  <= ADDR_W'(BASE_ADDR);
            mem_wdata_q <= 32'h0;
            words_q     <= '0;
            last_q      <= 1'b0;
            full_q      <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            words_q     <= words_d;
            last_q      <= last_d;
            full_q      <= full_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACCEPT: begin
                if (in_valid) begin
                    if (legal)        state_d = S_WRITE;
                    else if (in_last) state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (mem_ack) state_d = last_q ? S_DONE : S_ACCEPT;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_ACCEPT;
        endcase
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        words_d     = words_q;
        last_d      = last_q;
        full_d      = full_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        if (state_q == S_ACCEPT && in_valid) begin
            if (fmt == F_BAD) begin
                err_valid_d = 1'b1;
                err_code_d  = 2'd1;
            end else if (!imm_ok) begin
                err_valid_d = 1'b1;
                err_code_d  = 2'd2;
            end else if (full_q) begin
                err_valid_d = 1'b1;
                err_code_d  = 2'd3;
            end else begin
                mem_wdata_d = enc;
                last_d      = in_last;
            end
        end
        // The top address is written once and then latches full instead of wrapping
        if (state_q == S_WRITE && mem_ack) begin
            words_d = words_q + (ADDR_W+1)'(1);
            if (mem_addr_q == {ADDR_W{1'b1}}) full_d = 1'b1;
            else mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
    end

    always_comb begin
        in_ready = state_q == S_ACCEPT;
        mem_we   = state_q == S_WRITE;
        done     = state_q == S_DONE;
    end

    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign words_written = words_q;
    assign err_valid     = err_valid_q;
    assign err_code      = err_code_q;
endmodule
